// File: rtl/sram_sched_pkg.sv
// Shared encodings for the record/playback SRAM scheduler.
// Mode values double as the external mode output code.
package sram_sched_pkg;

    localparam int ADDR_W_DEF = 18;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_PLAY = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_STROBE = 2'd1,
        A_END    = 2'd2
    } acc_state_t;

endpackage

// File: rtl/sram_port_fsm.sv
// SRAM bus cycle generator: one access = accept, ACC_CYC strobe cycles, one end cycle.
// All bus outputs are registered from the next state so the strobes are glitch-free.
//
//   state    | meaning
//   A_IDLE   | bus released, ready to accept a request
//   A_STROBE | ce low, we or oe low, down-counter timing the strobe
//   A_END    | strobe released, addr/data held, done pulses
module sram_port_fsm
    import sram_sched_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ACC_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_data,
    input  logic [15:0]       io_i,
    output logic              busy,
    output logic              done_wr,
    output logic              done_rd,
    output logic              rd_valid,
    output logic [15:0]       rd_data,
    output logic [ADDR_W-1:0] addr_o,
    output logic              ce,
    output logic              oe,
    output logic              we,
    output logic              ub,
    output logic              lb,
    output logic [15:0]       io_o,
    output logic              io_oe
);

    localparam logic [2:0] CNT_LOAD = 3'(ACC_CYC - 1);

    acc_state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       wr_q, wr_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_n    = wr_q;
        case (state)
            A_IDLE: begin
                if (req) begin
                    state_n = A_STROBE;
                    cnt_n   = CNT_LOAD;
                    wr_n    = req_wr;
                end
            end
            A_STROBE: begin
                if (cnt == 3'd0) state_n = A_END;
                else             cnt_n   = cnt - 3'd1;
            end
            A_END:   state_n = A_IDLE;
            default: state_n = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= A_IDLE;
            cnt      <= '0;
            wr_q     <= 1'b0;
            addr_o   <= '0;
            io_o     <= '0;
            rd_data  <= '0;
            ce       <= 1'b1;
            ub       <= 1'b1;
            lb       <= 1'b1;
            we       <= 1'b1;
            oe       <= 1'b1;
            io_oe    <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wr_q  <= wr_n;
            if (state == A_IDLE && req) begin
                addr_o <= req_addr;
                if (req_wr) io_o <= req_data;
            end
            // io_i is sampled while oe is still low on the final strobe cycle
            if (state == A_STROBE && cnt == 3'd0 && !wr_q) rd_data <= io_i;
            ce       <= (state_n == A_IDLE);
            ub       <= (state_n == A_IDLE);
            lb       <= (state_n == A_IDLE);
            we       <= !(state_n == A_STROBE && wr_n);
            oe       <= !(state_n == A_STROBE && !wr_n);
            io_oe    <= (state_n != A_IDLE) && wr_n;
            rd_valid <= (state_n == A_END) && !wr_n;
        end
    end

    assign busy    = (state != A_IDLE);
    assign done_wr = (state == A_END) && wr_q;
    assign done_rd = (state == A_END) && !wr_q;

endmodule

// File: rtl/sram_sched.sv
// Record/playback mode sequencer: button edges, SRAM pointers, end-of-recording count.
//
//   state     | meaning
//   MODE_IDLE | no transfers; waits for a record or play edge
//   MODE_REC  | ADC write requests go to SRAM at wr_ptr
//   MODE_PLAY | DAC read requests fetch from rd_ptr up to end_cnt
module sram_sched
    import sram_sched_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ACC_CYC = 2,
    parameter int LOOP    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              record,
    input  logic              wr_req,
    input  logic [15:0]       wr_data,
    input  logic              rd_req,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] addr_o,
    output logic              ce,
    output logic              oe,
    output logic              we,
    output logic              ub,
    output logic              lb,
    output logic [15:0]       io_o,
    output logic              io_oe,
    input  logic [15:0]       io_i,
    output logic [1:0]        mode,
    output logic [ADDR_W:0]   end_cnt,
    output logic              ovf
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    mode_t           mode_q, mode_n;
    logic [ADDR_W:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, end_cnt_n;
    logic            ovf_n;
    logic            play_q, record_q, play_rise, rec_rise;
    logic            wr_ok, rd_ok, acc_req, busy, done_wr, done_rd;

    assign play_rise = play & ~play_q;
    assign rec_rise  = record & ~record_q;
    assign wr_ok     = wr_req && (mode_q == MODE_REC);
    assign rd_ok     = rd_req && (mode_q == MODE_PLAY);
    assign acc_req   = (wr_ok || rd_ok) && !busy;

    always_comb begin
        mode_n    = mode_q;
        wr_ptr_n  = done_wr ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_n  = done_rd ? rd_ptr + 1'b1 : rd_ptr;
        end_cnt_n = end_cnt;
        ovf_n     = ovf | ((wr_ok || rd_ok) && busy);
        // a write still in flight when REC was left must land in end_cnt
        if (done_wr && mode_q != MODE_REC) end_cnt_n = wr_ptr_n;
        case (mode_q)
            MODE_IDLE: begin
                if (rec_rise) begin
                    mode_n   = MODE_REC;
                    wr_ptr_n = '0;
                    ovf_n    = 1'b0;
                end else if (play_rise && end_cnt != '0) begin
                    mode_n   = MODE_PLAY;
                    rd_ptr_n = '0;
                    ovf_n    = 1'b0;
                end
            end
            MODE_REC: begin
                if (rec_rise || play_rise) begin
                    mode_n    = MODE_IDLE;
                    end_cnt_n = wr_ptr_n;
                end else if (done_wr && wr_ptr_n == CAP) begin
                    mode_n    = MODE_IDLE;
                    end_cnt_n = CAP;
                end
            end
            MODE_PLAY: begin
                if (rec_rise || play_rise) begin
                    mode_n = MODE_IDLE;
                end else if (done_rd && rd_ptr_n == end_cnt) begin
                    if (LOOP != 0) rd_ptr_n = '0;
                    else           mode_n   = MODE_IDLE;
                end
            end
            default: mode_n = MODE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            end_cnt  <= '0;
            ovf      <= 1'b0;
            play_q   <= 1'b0;
            record_q <= 1'b0;
        end else begin
            mode_q   <= mode_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            end_cnt  <= end_cnt_n;
            ovf      <= ovf_n;
            play_q   <= play;
            record_q <= record;
        end
    end

    assign mode = mode_q;

    sram_port_fsm #(
        .ADDR_W (ADDR_W),
        .ACC_CYC(ACC_CYC)
    ) u_port (
        .clk     (clk),
        .reset   (reset),
        .req     (acc_req),
        .req_wr  (wr_ok),
        .req_addr(wr_ok ? wr_ptr[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0]),
        .req_data(wr_data),
        .io_i    (io_i),
        .busy    (busy),
        .done_wr (done_wr),
        .done_rd (done_rd),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .addr_o  (addr_o),
        .ce      (ce),
        .oe      (oe),
        .we      (we),
        .ub      (ub),
        .lb      (lb),
        .io_o    (io_o),
        .io_oe   (io_oe)
    );

endmodule

// File: tb/tb_sram_sched.sv
// Bench for sram_sched: two 4-bit-address instances (LOOP=0 and LOOP=1), each with a bus-level SRAM.
// Expected data comes from a queue of what was recorded; bus activity is counted per instance.
module tb_sram_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play[2], record[2], wr_req[2], rd_req[2];
    logic [15:0] wr_data[2], rd_data[2], io_o[2], io_i[2];
    logic        rd_valid[2], ce[2], oe[2], we[2], ub[2], lb[2], io_oe[2], ovf[2];
    logic [3:0]  addr_o[2];
    logic [1:0]  mode[2];
    logic [4:0]  end_cnt[2];

    logic [15:0] sram[2][16];
    int ce_low_cnt[2]   = '{0, 0};
    int rdv_cnt[2]      = '{0, 0};
    int wr_cnt[2]       = '{0, 0};
    int we_cur[2]       = '{0, 0};
    int last_we_run[2]  = '{0, 0};
    int last_wr_addr[2] = '{0, 0};

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_sched #(.ADDR_W(4), .ACC_CYC(2), .LOOP(g)) dut (
            .clk(clk), .reset(reset), .play(play[g]), .record(record[g]),
            .wr_req(wr_req[g]), .wr_data(wr_data[g]), .rd_req(rd_req[g]),
            .rd_data(rd_data[g]), .rd_valid(rd_valid[g]), .addr_o(addr_o[g]),
            .ce(ce[g]), .oe(oe[g]), .we(we[g]), .ub(ub[g]), .lb(lb[g]),
            .io_o(io_o[g]), .io_oe(io_oe[g]), .io_i(io_i[g]),
            .mode(mode[g]), .end_cnt(end_cnt[g]), .ovf(ovf[g])
        );
        assign io_i[g] = sram[g][addr_o[g]];
    end

    // bus monitor and SRAM array
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!ce[i]) ce_low_cnt[i] <= ce_low_cnt[i] + 1;
            if (rd_valid[i]) rdv_cnt[i] <= rdv_cnt[i] + 1;
            if (!ce[i] && !we[i]) begin
                if (we_cur[i] == 0) begin
                    wr_cnt[i]       <= wr_cnt[i] + 1;
                    last_wr_addr[i] <= int'(addr_o[i]);
                end
                sram[i][addr_o[i]] <= io_o[i];
                we_cur[i]          <= we_cur[i] + 1;
            end else if (we_cur[i] != 0) begin
                last_we_run[i] <= we_cur[i];
                we_cur[i]      <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int g, input bit is_rec);
        if (is_rec) record[g] = 1'b1; else play[g] = 1'b1;
        tick(1);
        record[g] = 1'b0;
        play[g]   = 1'b0;
        tick(1);
    endtask

    task automatic do_write(input int g, input logic [15:0] d, input int exp_addr, input bit exp_acc);
        int c0 = wr_cnt[g];
        int e0 = ce_low_cnt[g];
        wr_data[g] = d;
        wr_req[g]  = 1'b1;
        tick(1);
        wr_req[g] = 1'b0;
        chk("wr_io_oe", io_oe[g], exp_acc);
        tick(5);
        chk("wr_count", wr_cnt[g] - c0, exp_acc);
        chk("wr_ce_cycles", ce_low_cnt[g] - e0, exp_acc ? 3 : 0);
        if (exp_acc) begin
            chk("wr_addr", last_wr_addr[g], exp_addr);
            chk("we_width", last_we_run[g], 2);
            chk("wr_data", sram[g][exp_addr[3:0]], d);
        end
    endtask

    task automatic do_read(input int g, input bit exp_valid, input logic [15:0] exp_d);
        int v0 = rdv_cnt[g];
        int e0 = ce_low_cnt[g];
        rd_req[g] = 1'b1;
        tick(1);
        rd_req[g] = 1'b0;
        tick(1);
        chk("rd_valid_early", rd_valid[g], 0);
        tick(1);
        chk("rd_valid_lat", rd_valid[g], exp_valid);
        if (exp_valid) chk("rd_data", rd_data[g], exp_d);
        tick(3);
        chk("rd_valid_count", rdv_cnt[g] - v0, exp_valid);
        chk("rd_ce_cycles", ce_low_cnt[g] - e0, exp_valid ? 3 : 0);
    endtask

    initial begin
        logic [15:0] d;
        int n, e0;
        for (int i = 0; i < 2; i++) begin
            play[i] = 0; record[i] = 0; wr_req[i] = 0; rd_req[i] = 0; wr_data[i] = '0;
        end
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_mode", mode[0], 0);
        chk("rst_addr", addr_o[0], 0);
        chk("rst_strobes", {ce[0], oe[0], we[0], ub[0], lb[0]}, 5'b11111);
        chk("rst_io_oe", io_oe[0], 0);
        chk("rst_rd", {rd_valid[0], rd_data[0]}, 0);
        chk("rst_end_ovf", {end_cnt[0], ovf[0]}, 0);

        // play with nothing recorded is ignored
        e0 = ce_low_cnt[0];
        pulse(0, 0);
        tick(4);
        chk("play_empty_mode", mode[0], 0);
        chk("play_empty_ce", ce_low_cnt[0] - e0, 0);

        // directed record of three samples, then playback with one extra request
        pulse(0, 1);
        chk("rec_mode", mode[0], 1);
        do_write(0, 16'h1111, 0, 1); tick(58);
        do_write(0, 16'h2222, 1, 1); tick(58);
        do_write(0, 16'h3333, 2, 1); tick(58);
        pulse(0, 1);
        chk("rec_stop_mode", mode[0], 0);
        chk("rec_end_cnt", end_cnt[0], 3);
        pulse(0, 0);
        chk("play_mode", mode[0], 2);
        do_read(0, 1, 16'h1111); tick(58);
        do_read(0, 1, 16'h2222); tick(58);
        do_read(0, 1, 16'h3333);
        chk("play_autostop", mode[0], 0);
        tick(58);
        do_read(0, 0, 16'h0000);
        chk("play_end_kept", end_cnt[0], 3);

        // back-to-back write requests: second one overflows
        pulse(0, 1);
        e0 = wr_cnt[0];
        wr_data[0] = 16'hAAAA;
        wr_req[0]  = 1'b1;
        tick(1);
        wr_data[0] = 16'hBBBB;
        tick(1);
        wr_req[0] = 1'b0;
        tick(6);
        chk("ovf_writes", wr_cnt[0] - e0, 1);
        chk("ovf_data", sram[0][0], 16'hAAAA);
        chk("ovf_set", ovf[0], 1);
        pulse(0, 1);
        chk("ovf_end_cnt", end_cnt[0], 1);
        chk("ovf_sticky", ovf[0], 1);
        pulse(0, 1);
        chk("ovf_cleared", ovf[0], 0);

        // stop edge lands while a write is mid-access
        do_write(0, 16'h4444, 0, 1);
        e0 = wr_cnt[0];
        wr_data[0] = 16'h5555;
        wr_req[0]  = 1'b1;
        tick(1);
        wr_req[0] = 1'b0;
        tick(1);
        record[0] = 1'b1;
        tick(1);
        record[0] = 1'b0;
        tick(4);
        chk("mid_mode", mode[0], 0);
        chk("mid_end_cnt", end_cnt[0], 2);
        chk("mid_write", wr_cnt[0] - e0, 1);
        chk("mid_addr", last_wr_addr[0], 1);

        // randomized record/playback sessions against the recorded-data queue
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 8);
            exp_q.delete();
            pulse(0, 1);
            for (int i = 0; i < n; i++) begin
                d = {4'(i), 12'($urandom)};
                exp_q.push_back(d);
                do_write(0, d, i, 1);
                tick($urandom_range(0, 6));
            end
            pulse(0, 1);
            chk("rnd_end_cnt", end_cnt[0], n);
            pulse(0, 0);
            for (int i = 0; i < n; i++) begin
                chk("rnd_mode_play", mode[0], 2);
                do_read(0, 1, exp_q[i]);
                tick($urandom_range(0, 6));
            end
            chk("rnd_autostop", mode[0], 0);
        end

        // fill the whole 16-word array: auto-stop on both instances
        for (int g = 0; g < 2; g++) begin
            exp_q.delete();
            pulse(g, 1);
            for (int i = 0; i < 16; i++) begin
                d = {4'(i), 12'($urandom)};
                exp_q.push_back(d);
                do_write(g, d, i, 1);
            end
            chk("full_mode", mode[g], 0);
            chk("full_end_cnt", end_cnt[g], 16);
            do_write(g, 16'hDEAD, 0, 0);
            if (g == 1) begin
                pulse(1, 0);
                for (int i = 0; i < 20; i++) begin
                    do_read(1, 1, exp_q[i % 16]);
                end
                chk("loop_mode", mode[1], 2);
            end
        end

        // reset in the middle of a read strobe
        rd_req[1] = 1'b1;
        tick(1);
        rd_req[1] = 1'b0;
        chk("pre_rst_oe", {ce[1], oe[1]}, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_strobes", {ce[1], oe[1], we[1], io_oe[1]}, 4'b1110);
        chk("async_rst_mode", mode[1], 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_sched.md
Name: sram_sched

Overview:
- Record/playback sequencer and SRAM access scheduler for the audio recorder.
- Takes debounced play/record levels and runs the mode FSM (IDLE/REC/PLAY).
- Owns the SRAM address pointers and the end-of-recording count.
- Converts single-cycle ADC write requests and DAC read requests into timed SRAM bus cycles, replacing the per-codec address drivers.

Parameters:
- ADDR_W, 18, SRAM address width; capacity is 2^ADDR_W words.
- ACC_CYC, 2, clk cycles the strobe (we or oe) is held low per access; legal range 1..7.
- LOOP, 0, 1 = playback restarts at address 0 on reaching the end instead of stopping.

Ports:
- clk  input  1  system clock (12 MHz PLL output)
- reset  input  1  asynchronous, active-high reset
- play  input  1  debounced play button level, clk-synchronous
- record  input  1  debounced record button level, clk-synchronous
- wr_req  input  1  one-cycle pulse: wr_data holds a new ADC sample
- wr_data  input  16  sample to store
- rd_req  input  1  one-cycle pulse: DAC wants the next sample
- rd_data  output  16  sample read from SRAM
- rd_valid  output  1  one-cycle pulse: rd_data is valid
- addr_o  output  ADDR_W  SRAM address
- ce, oe, we, ub, lb  output  1 each  SRAM strobes, active-low
- io_o  output  16  SRAM write data
- io_oe  output  1  1 = drive SRAM io bus with io_o
- io_i  input  16  SRAM io bus read-back
- mode  output  2  0 = IDLE, 1 = REC, 2 = PLAY
- end_cnt  output  ADDR_W+1  number of samples recorded
- ovf  output  1  sticky: a request arrived while an access was busy

Behaviour:
- Reset values: mode = IDLE; addr_o, wr_ptr, rd_ptr, end_cnt, rd_data = 0; ce = oe = we = ub = lb = 1; io_oe = 0; rd_valid = 0; ovf = 0.
- Reset is asynchronous. Asserting it mid-access forces the strobes high and io_oe low immediately.
- Edge detect: register play and record; act on rising edges only.
- IDLE state:
  - record edge -> REC; wr_ptr = 0; ovf cleared.
  - Otherwise, play edge with end_cnt != 0 -> PLAY; rd_ptr = 0; ovf cleared.
  - Record wins when both edges arrive in the same cycle.
  - A play edge with end_cnt == 0 is ignored.
- REC state: any edge (play or record) -> IDLE, with end_cnt = wr_ptr.
- PLAY state: any edge -> IDLE; end_cnt is unchanged.
- Auto-stop in REC: when wr_ptr reaches 2^ADDR_W after a write -> IDLE, with end_cnt = 2^ADDR_W.
- Auto-stop in PLAY: when rd_ptr reaches end_cnt after a read:
  - LOOP = 0 -> IDLE.
  - LOOP = 1 -> rd_ptr = 0 and stay in PLAY.
- Request acceptance:
  - wr_req is accepted only in REC; rd_req only in PLAY. Requests in any other mode are dropped silently.
  - A request arriving while the access FSM is not A_IDLE is dropped and sets ovf.
- Access FSM states: A_IDLE, A_STROBE, A_END.
- Write access:
  - Accept cycle: latch addr_o = wr_ptr and io_o = wr_data; set io_oe = 1 and ce = ub = lb = 0.
  - A_STROBE: we = 0 for ACC_CYC cycles.
  - A_END: we = 1 while addr and data are held for 1 cycle; then io_oe = 0, ce = ub = lb = 1, and wr_ptr increments.
- Read access:
  - Accept cycle: addr_o = rd_ptr; ce = ub = lb = 0.
  - A_STROBE: oe = 0 for ACC_CYC cycles; io_i is sampled into rd_data on the last strobe cycle.
  - A_END: oe = 1, rd_valid pulses, rd_ptr increments, ce = ub = lb = 1.
- Latency: rd_valid asserts ACC_CYC+1 cycles after the rd_req cycle; a full access occupies ACC_CYC+2 cycles.
- Mode change during an access: the access completes and updates its pointer.
  - The REC->IDLE end_cnt capture includes that completed write.
  - The next request is judged against the new mode.
- Pointer arithmetic:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide; addr_o uses the low ADDR_W bits.
  - No wrap in REC; the auto-stop occurs first.

Decomposition:
- Package sram_sched_pkg holds:
  - mode encodings MODE_IDLE, MODE_REC, MODE_PLAY;
  - access-state enum A_IDLE, A_STROBE, A_END;
  - the default ADDR_W.
- One sub-module, sram_port_fsm: the access FSM, strobe/io_oe timing and the ACC_CYC counter. It gets a request plus direction, address and data, and returns done and rd_data.
- The top holds the mode FSM, edge detection, pointers, end_cnt and ovf.

Test Plan:
- Reset, then record edge, then 3 wr_req with 0x1111, 0x2222, 0x3333 spaced 64 cycles, then record edge -> writes to addr 0, 1, 2; we low exactly 2 cycles each (ACC_CYC = 2); end_cnt = 3; mode back to 0.
- Play edge after the above, then 4 rd_req spaced 64 cycles, with a model SRAM -> rd_data 0x1111, 0x2222, 0x3333 with rd_valid 3 cycles after each req; mode = IDLE after the third read; 4th req dropped, no rd_valid.
- Play edge with end_cnt = 0 -> mode stays 0; no strobes toggle.
- In REC, wr_req on two consecutive cycles -> one write performed; ovf = 1; ovf cleared on the next REC entry.
- In REC, record edge in the same cycle as a wr_req that is already mid-access -> the write completes; end_cnt includes it; mode = 0 after completion.
- ADDR_W = 4: 16 writes -> auto-stop with end_cnt = 16. Then with LOOP = 1, 20 reads -> addresses 0..15 then 0..3, and mode stays PLAY. Also assert reset mid-strobe -> we, oe and ce high in the same cycle.
